// File: rtl/grid_axil_pkg.sv
// Shared constants, types and the byte-merge helper for the grid AXI4-Lite register block.
package grid_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         GRID_AXIL_DW = 32;

  // Wide enough for any ADDR_WIDTH up to 10; narrower indices are zero-extended.
  typedef logic [7:0] reg_idx_t;

  function automatic logic [GRID_AXIL_DW-1:0] byte_merge(
    input logic [GRID_AXIL_DW-1:0] old_v,
    input logic [GRID_AXIL_DW-1:0] wdata,
    input logic [3:0]              wstrb
  );
    logic [GRID_AXIL_DW-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) begin
        res[b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/grid_axil_reg_byte_en.sv
// One 32-bit control register; byte lanes selected by wstrb_i update on a commit strobe.
module grid_axil_reg_byte_en
  import grid_axil_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    commit_i,
  input  logic [3:0]              wstrb_i,
  input  logic [GRID_AXIL_DW-1:0] wdata_i,
  output logic [GRID_AXIL_DW-1:0] q_o
);

  logic [GRID_AXIL_DW-1:0] val_q;
  logic [GRID_AXIL_DW-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (commit_i) begin
      val_d = byte_merge(val_q, wdata_i, wstrb_i);
    end else begin
      val_d = val_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/grid_axil_slave_regs.sv
// AXI4-Lite responder and NUM_REGS-entry register file for the grid controller.
// Define GRID_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module grid_axil_slave_regs
  import grid_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [3:0]                   S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]       regs_o,
  output logic [NUM_REGS-1:0]          reg_wr_o
);

`ifdef GRID_AXIL_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                    awready_q, awready_d, wready_q, wready_d;
  logic                    bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  reg_idx_t                aw_idx_q, aw_idx_d;
  logic [GRID_AXIL_DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [NUM_REGS-1:0]     reg_wr_q, wr_sel_s;
  logic                    aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_in_range_s, rd_in_range_s;
  reg_idx_t                ar_idx_s;
  logic [GRID_AXIL_DW-1:0] rd_val_s;
  logic [GRID_AXIL_DW-1:0] reg_val_s [NUM_REGS];
  logic                    unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    aw_hs_s       = S_AXI_AWVALID && awready_q;
    w_hs_s        = S_AXI_WVALID && wready_q;
    commit_s      = aw_held_q && w_held_q;
    wr_in_range_s = (aw_idx_q < reg_idx_t'(NUM_REGS));
    wr_sel_s      = '0;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    aw_idx_d      = aw_idx_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    if (commit_s) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        wr_sel_s[k] = wr_in_range_s && (aw_idx_q == reg_idx_t'(k));
      end
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range_s ? RESP_OKAY : OOR_RESP;
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        aw_idx_d  = reg_idx_t'(S_AXI_AWADDR[ADDR_WIDTH-1:2]);
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
      end else begin
        w_held_d = w_held_q;
      end
      if (bvalid_q && S_AXI_BREADY) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
    // Ready flops track the next-state flags so they match the combinational definition.
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  always_comb begin
    ar_hs_s       = S_AXI_ARVALID && arready_q;
    ar_idx_s      = reg_idx_t'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
    rd_in_range_s = (ar_idx_s < reg_idx_t'(NUM_REGS));
    rd_val_s      = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx_s == reg_idx_t'(k)) begin
        rd_val_s = reg_val_s[k];
      end else begin
        rd_val_s = rd_val_s;
      end
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val_s;
      rresp_d  = rd_in_range_s ? RESP_OKAY : OOR_RESP;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'h0;
      reg_wr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      reg_wr_q  <= wr_sel_s;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    grid_axil_reg_byte_en u_reg (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .commit_i (wr_sel_s[k]),
      .wstrb_i  (wstrb_q),
      .wdata_i  (wdata_q),
      .q_o      (reg_val_s[k])
    );
    assign regs_o[k*32 +: 32] = reg_val_s[k];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_wr_o      = reg_wr_q;

endmodule

// File: tb/tb_grid_axil_slave_regs.sv
// Directed self-checking bench for grid_axil_slave_regs (ADDR_WIDTH=5 so 0x10 is out of range).
module tb_grid_axil_slave_regs;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [4:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata = '0, rdata;
  logic [3:0]   wstrb = '0;
  logic [1:0]   bresp, rresp;
  logic [127:0] regs;
  logic [3:0]   reg_wr;
  int           checks = 0;
  int           errors = 0;

`ifdef GRID_AXIL_SLVERR_EN
  localparam logic [1:0] OOR_EXP = 2'b10;
`else
  localparam logic [1:0] OOR_EXP = 2'b00;
`endif

  always #5 aclk = ~aclk;

  grid_axil_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_o(regs), .reg_wr_o(reg_wr)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [3:0] pulse);
    int  n;
    logic aw_go, w_go;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      tick();
      if (aw_go) awvalid = 1'b0;
      if (w_go) wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, bvalid);
    end
    resp  = bresp;
    pulse = reg_wr;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int  n;
    logic ar_go;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      ar_go = arready;
      tick();
      if (ar_go) arvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, rvalid);
    end
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    arvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctl got=%b required 00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({regs, reg_wr, rdata, bresp, rresp} !== '0) begin
      errors++;
      $display("FAIL reset_data regs=%h wr=%b rdata=%h required zero", regs, reg_wr, rdata);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_sequential();
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp, pulse);
      checks++;
      if (resp !== 2'b00 || pulse !== 4'(1 << i)) begin
        errors++;
        $display("FAIL seq_write%0d resp=%b pulse=%b required 00 %b", i, resp, pulse, 4'(1 << i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, resp);
      checks++;
      if (d !== 32'(i + 1) || resp !== 2'b00) begin
        errors++;
        $display("FAIL seq_read%0d got=%h/%b required %h/00", i, d, resp, 32'(i + 1));
      end
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b0) begin
        errors++;
        $display("FAIL w_first_early_commit cyc=%0d bvalid=%b required 0", i, bvalid);
      end
    end
    awaddr = 5'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL w_first_aw_edge bvalid=%b required 0", bvalid);
    end
    tick();
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || regs[63:32] !== 32'hDEADBEEF || reg_wr !== 4'b0010) begin
      errors++;
      $display("FAIL w_first_commit bvalid=%b bresp=%b reg1=%h wr=%b required 1 00 deadbeef 0010",
               bvalid, bresp, regs[63:32], reg_wr);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_strobe();
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] d;
    axi_write(5'h00, 32'h11223344, 4'hF, resp, pulse);
    axi_write(5'h00, 32'hAABBCCDD, 4'b0101, resp, pulse);
    axi_read(5'h00, d, resp);
    checks++;
    if (d !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_merge got=%h required 11bb33dd", d);
    end
    axi_write(5'h00, 32'h99999999, 4'h0, resp, pulse);
    checks++;
    if (resp !== 2'b00 || pulse !== 4'b0001 || regs[31:0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_zero resp=%b pulse=%b reg0=%h required 00 0001 11bb33dd", resp, pulse, regs[31:0]);
    end
  endtask

  task automatic test_backpressure();
    awaddr = 5'h0C; wdata = 32'h00000077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h00; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || rvalid !== 1'b1 || rdata !== 32'h11BB33DD ||
          rresp !== 2'b00 || {awready, wready, arready} !== 3'b000) begin
        errors++;
        $display("FAIL backpressure cyc=%0d bv=%b br=%b rv=%b rd=%h rr=%b rdy=%b required 1 00 1 11bb33dd 00 000",
                 i, bvalid, bresp, rvalid, rdata, rresp, {awready, wready, arready});
      end
      tick();
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    checks++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111 || regs[127:96] !== 32'h00000077) begin
      errors++;
      $display("FAIL backpressure_release got=%b reg3=%h required 00111 00000077",
               {bvalid, rvalid, awready, wready, arready}, regs[127:96]);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] d;
    logic [1:0]  resp;
    awaddr = 5'h08; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h08; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h00000003) begin
      errors++;
      $display("FAIL same_edge_read bvalid=%b rvalid=%b rdata=%h required 1 1 00000003", bvalid, rvalid, rdata);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(5'h08, d, resp);
    checks++;
    if (d !== 32'h00000055) begin
      errors++;
      $display("FAIL same_edge_followup got=%h required 00000055", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] d;
    axi_write(5'h10, 32'hCAFEF00D, 4'hF, resp, pulse);
    checks++;
    if (resp !== OOR_EXP || pulse !== 4'b0000 ||
        regs !== {32'h00000077, 32'h00000055, 32'hDEADBEEF, 32'h11BB33DD}) begin
      errors++;
      $display("FAIL oor_write resp=%b pulse=%b regs=%h required %b 0000 unchanged", resp, pulse, regs, OOR_EXP);
    end
    axi_read(5'h10, d, resp);
    checks++;
    if (d !== 32'h0 || resp !== OOR_EXP) begin
      errors++;
      $display("FAIL oor_read got=%h/%b required 00000000/%b", d, resp, OOR_EXP);
    end
  endtask

  task automatic test_reset_mid();
    awaddr = 5'h04; awvalid = 1'b1; araddr = 5'h00; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre rvalid=%b required 1", rvalid);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b0 || regs !== '0) begin
      errors++;
      $display("FAIL mid_reset_async rvalid=%b bvalid=%b awready=%b regs=%h required 0 0 0 0",
               rvalid, bvalid, awready, regs);
    end
    tick();
    aresetn = 1'b1;
    tick();
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b0 || regs !== '0) begin
        errors++;
        $display("FAIL mid_reset_partial cyc=%0d bvalid=%b regs=%h required 0 0", i, bvalid, regs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_w_before_aw();
    test_strobe();
    test_backpressure();
    test_same_edge();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
